sample_voice_mixer: RTL and testbench
=====================================

# sample_voice_mixer

Downstream consumer of the sample address counter. On each `sample_tick` it captures the current sample address and the 8-bit gate vector. It then sequences eight reads from the shared sample BRAM, one region per voice, and sums the samples of the gated voices. It emits one mixed PCM sample per tick to the output (PWM/DAC) stage.

## Interface
- `SAMPLE_WIDTH`, 8: width of a stored sample and of `mix_out` (offset-binary, unsigned).
- `ADDR_WIDTH`, 13: per-voice sample address width.
- `BRAM_LATENCY`, 2: cycles from `bram_addr` presentation to valid `bram_dout`.

- `clk_in`  in  1  system clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `sample_tick`  in  1  one-cycle pulse at the audio sample rate.
- `gate_in`  in  8  per-voice gate; bit v enables voice v.
- `sample_addr`  in  ADDR_WIDTH  current address from the sample address counter.
- `bram_addr`  out  ADDR_WIDTH+3  read address `{voice[2:0], addr}`.
- `bram_dout`  in  SAMPLE_WIDTH  BRAM read data.
- `mix_out`  out  SAMPLE_WIDTH  mixed sample, offset-binary, held between updates.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `busy`  out  1  high from the cycle after the accepted tick through the `mix_valid` cycle.

## Operation
- **States:**
  - IDLE: waits for a tick. On `sample_tick`, latch `sample_addr` into `addr_q` and `gate_in` into `gate_q`, then go to ISSUE.
  - ISSUE: 8 cycles. Drive `bram_addr = {v, addr_q}` for v = 0..7, one voice per cycle, then go to DRAIN.
  - DRAIN: `BRAM_LATENCY` cycles to collect the outstanding read data, then go to OUTPUT.
  - OUTPUT: 1 cycle. Drive `mix_out` and pulse `mix_valid`, then go to IDLE.
- **Voice tag pipeline:** a `BRAM_LATENCY`-deep shift register carries (voice index, read-valid) alongside each issued read. The returned data is then attributed to the correct voice.
- **Per returned sample:**
  - Convert to signed by inverting the MSB.
  - If `gate_q[v]` is 1, add it to the accumulator; otherwise add 0.
  - The accumulator is signed, SAMPLE_WIDTH+3 bits wide, and is cleared when a tick is accepted.
- **Output conversion:** reduce the accumulator to SAMPLE_WIDTH signed bits (see Configuration), then invert the MSB back to offset-binary.
- **`gate_q` == 0:** the sequence still runs. The result is midscale (0x80 for width 8), and `mix_valid` still pulses.
- **Tick while busy:** `sample_tick` asserted while `busy` is high is ignored. No restart, no queueing.
- **Changing inputs:** `gate_in` and `sample_addr` changes after capture do not affect the sample in progress.
- **`bram_addr` outside ISSUE:** holds its last value. BRAM reads in other cycles are harmless.
- **Reset values:**
  - state IDLE.
  - `mix_out` = 1 << (SAMPLE_WIDTH-1) (midscale).
  - `mix_valid` = 0, `busy` = 0, `bram_addr` = 0.
  - accumulator 0, tag pipeline cleared.
- **Reset mid-operation:** aborts the sequence and discards partial sums. No `mix_valid` is produced for the aborted sample.

## Timing
- Tick accepted at cycle T. `bram_addr` carries voice v at cycle T+1+v.
- Voice v data is valid at cycle T+1+v+BRAM_LATENCY.
- The last sample is accumulated at T+8+BRAM_LATENCY.
- `mix_valid` and the new `mix_out` appear at T+9+BRAM_LATENCY, which is T+11 with defaults.
- `busy` is high from T+1 to T+9+BRAM_LATENCY inclusive. The earliest next accepted tick is at T+10+BRAM_LATENCY.
- The tick is captured in the same cycle that the counter advances. `addr_q` therefore holds the pre-increment address, which is intended.

## Configuration
- **`MIX_SATURATE_EN` defined:** the accumulator is clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1], i.e. [-128, 127] for width 8. Single voices play at full scale, and overflow clips.
- **`MIX_SATURATE_EN` undefined:** result = accumulator >>> 3 (arithmetic shift, truncating toward -inf). The output never clips and every voice is attenuated by 1/8.

## Test plan
- Reset, then idle 20 cycles -> `mix_out` = 0x80, `mix_valid` never asserted, `busy` = 0.
- BRAM model, latency 2: voice v at any address returns 0x80+16·v; `gate_in` = 0x01; tick at T -> `bram_addr` sequence {0..7, addr} at T+1..T+8, `mix_valid` at T+11.
  - Saturate build: `mix_out` = 0x80.
  - Shift build: `mix_out` = 0x80.
- Same BRAM model, `gate_in` = 0x0C (voices 2 and 3, +32 and +48):
  - Saturate build: `mix_out` = 0xD0.
  - Shift build: `mix_out` = 0x8A.
- All voices return 0xFF, `gate_in` = 0xFF:
  - Saturate build: accumulator 1016 clamps to 127, `mix_out` = 0xFF.
  - Shift build: 1016>>>3 = 127, `mix_out` = 0xFF.
- All voices return 0x00, `gate_in` = 0xFF:
  - Saturate build: `mix_out` = 0x00.
  - Shift build: -1024>>>3 = -128, `mix_out` = 0x00.
- Second tick at T+5, and `gate_in` changed at T+3 -> second tick ignored, exactly one `mix_valid` at T+11 using the gates captured at T.
- `rst_in` pulsed at T+6 -> no `mix_valid`, outputs at reset values. A tick at T+8 is accepted normally with `mix_valid` at T+19.

Source files
------------

// File: rtl/sample_voice_mixer.sv
// Eight-voice sample mixer: on each accepted tick, reads one sample per voice from the
// shared BRAM, sums the gated voices and emits one offset-binary PCM sample.
// Build option: define MIX_SATURATE_EN to clamp the sum; otherwise the sum is scaled by 1/8.
module sample_voice_mixer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 13,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sample_tick,
  input  logic [7:0]              gate_in,
  input  logic [ADDR_WIDTH-1:0]   sample_addr,
  output logic [ADDR_WIDTH+2:0]   bram_addr,
  input  logic [SAMPLE_WIDTH-1:0] bram_dout,
  output logic [SAMPLE_WIDTH-1:0] mix_out,
  output logic                    mix_valid,
  output logic                    busy
);

  localparam int ACC_W = SAMPLE_WIDTH + 3;
  localparam int CNT_W = (BRAM_LATENCY > 8) ? $clog2(BRAM_LATENCY) : 3;

  localparam logic [SAMPLE_WIDTH-1:0] MIDSCALE = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUTPUT
  } state_e;

  // Travels alongside each read so returned data can be credited to its voice.
  typedef struct packed {
    logic       valid;
    logic [2:0] voice;
  } tag_t;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                gate_q;
  logic [CNT_W-1:0]          cnt_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  tag_t                      tag_q [BRAM_LATENCY];
  tag_t                      tag_d;
  tag_t                      tag_tail;
  logic [ADDR_WIDTH+2:0]     bram_addr_q;
  logic [SAMPLE_WIDTH-1:0]   mix_out_q;
  logic [SAMPLE_WIDTH-1:0]   mix_out_d;
  logic                      mix_valid_q;
  logic                      busy_q;

  logic signed [SAMPLE_WIDTH-1:0] sample_s;
  logic signed [SAMPLE_WIDTH-1:0] result_s;

`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {4'b0000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {4'b1111, {(SAMPLE_WIDTH-1){1'b0}}};
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    tag_tail = tag_q[BRAM_LATENCY-1];
    tag_d    = '0;
    if (state_q == ST_ISSUE) begin
      tag_d.valid = 1'b1;
      tag_d.voice = cnt_q[2:0];
    end

    // Offset-binary to two's complement is just an MSB flip.
    sample_s = {~bram_dout[SAMPLE_WIDTH-1], bram_dout[SAMPLE_WIDTH-2:0]};
    acc_d    = acc_q;
    if (tag_tail.valid && gate_q[tag_tail.voice]) begin
      acc_d = acc_q + {{3{sample_s[SAMPLE_WIDTH-1]}}, sample_s};
    end

`ifdef MIX_SATURATE_EN
    if (acc_d > SAT_MAX) begin
      result_s = SAT_MAX[SAMPLE_WIDTH-1:0];
    end else if (acc_d < SAT_MIN) begin
      result_s = SAT_MIN[SAMPLE_WIDTH-1:0];
    end else begin
      result_s = acc_d[SAMPLE_WIDTH-1:0];
    end
`else
    // Dropping the three LSBs of a signed value is an arithmetic shift right by 3.
    result_s = acc_d[ACC_W-1:3];
`endif

    mix_out_d = {~result_s[SAMPLE_WIDTH-1], result_s[SAMPLE_WIDTH-2:0]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // see the pre-edge values of one another.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      gate_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      bram_addr_q <= '0;
      mix_out_q   <= MIDSCALE;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the tag pipeline is a handful of flops, not a RAM, so clearing it
      // on reset is cheap and guarantees no stale read is credited afterwards.
      for (int i = 0; i < BRAM_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      mix_valid_q <= 1'b0;
      acc_q       <= acc_d;

      tag_q[0] <= tag_d;
      for (int i = 1; i < BRAM_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end

      case (state_q)
        ST_IDLE: begin
          if (sample_tick) begin
            addr_q      <= sample_addr;
            gate_q      <= gate_in;
            acc_q       <= '0;
            cnt_q       <= '0;
            bram_addr_q <= {3'd0, sample_addr};
            busy_q      <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            cnt_q       <= cnt_q + CNT_W'(1);
            bram_addr_q <= {cnt_q[2:0] + 3'd1, addr_q};
          end
        end

        ST_DRAIN: begin
          // The last voice's data is on bram_dout now, so acc_d is the final sum.
          if (cnt_q == CNT_W'(BRAM_LATENCY - 1)) begin
            cnt_q       <= '0;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= 1'b1;
            state_q     <= ST_OUTPUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_OUTPUT: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bram_addr = bram_addr_q;
  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sample_voice_mixer.sv
// Randomized self-checking bench for sample_voice_mixer against an arithmetic mix model
// and a latency-2 BRAM model.
module tb_sample_voice_mixer;

  logic        clk_in;
  logic        rst_in;
  logic        sample_tick;
  logic [7:0]  gate_in;
  logic [12:0] sample_addr;
  logic [15:0] bram_addr;
  logic [7:0]  bram_dout;
  logic [7:0]  mix_out;
  logic        mix_valid;
  logic        busy;

  int n_vec;
  int n_err;

  // BRAM content selector: 0 ramp per voice, 1 all 0xFF, 2 all 0x00, 3 random table.
  int         mode;
  logic [7:0] mem [65536];
  logic [7:0] rd1;

  sample_voice_mixer dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sample_tick (sample_tick),
    .gate_in     (gate_in),
    .sample_addr (sample_addr),
    .bram_addr   (bram_addr),
    .bram_dout   (bram_dout),
    .mix_out     (mix_out),
    .mix_valid   (mix_valid),
    .busy        (busy)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] bram_val(input logic [15:0] a);
    case (mode)
      0:       return 8'h80 + 8'(16 * int'(a[15:13]));
      1:       return 8'hFF;
      2:       return 8'h00;
      default: return mem[a];
    endcase
  endfunction

  always @(posedge clk_in) begin
    rd1       <= bram_val(bram_addr);
    bram_dout <= rd1;
  end

  function automatic int model(input logic [7:0] g, input logic [12:0] a);
    int sum;
    sum = 0;
    for (int v = 0; v < 8; v++) begin
      if (g[v]) sum += int'(bram_val({3'(v), a})) - 128;
    end
`ifdef MIX_SATURATE_EN
    if (sum > 127)  sum = 127;
    if (sum < -128) sum = -128;
`else
    sum = sum >>> 3;
`endif
    return sum + 128;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Tick in the current cycle T, then watch cycles T+1..T+14 with inputs scrambled.
  task automatic run_tick(input logic [7:0] g, input logic [12:0] a);
    int         exp;
    int         nvalid;
    int         seen_k;
    logic [7:0] got;
    logic [2:0] vv;
    exp    = model(g, a);
    nvalid = 0;
    seen_k = -1;
    got    = 8'h00;
    sample_tick = 1'b1;
    gate_in     = g;
    sample_addr = a;
    step();
    sample_tick = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 8) begin
        vv = 3'(k - 1);
        check("bram_addr", 32'(bram_addr), 32'({vv, a}));
      end
      if (k == 1)  check("busy_start", 32'(busy), 32'd1);
      if (k == 11) check("busy_last", 32'(busy), 32'd1);
      if (k == 12) check("busy_end", 32'(busy), 32'd0);
      if (mix_valid) begin
        nvalid++;
        seen_k = k;
        got    = mix_out;
      end
      gate_in     = 8'($urandom);
      sample_addr = 13'($urandom);
      step();
    end
    check("valid_count", 32'(nvalid), 32'd1);
    check("valid_cycle", 32'(seen_k), 32'd11);
    check("mix_out", 32'(got), 32'(exp));
  endtask

  initial begin
    int         nvalid;
    int         seen_k;
    int         exp;
    logic [7:0] got;
    logic [12:0] a;

    n_vec       = 0;
    n_err       = 0;
    mode        = 0;
    rst_in      = 1'b1;
    sample_tick = 1'b0;
    gate_in     = 8'h00;
    sample_addr = 13'h0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    repeat (3) step();
    rst_in = 1'b0;

    // Idle after reset: nothing moves.
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      if (mix_valid || busy) nvalid++;
      step();
    end
    check("idle_activity", 32'(nvalid), 32'd0);
    check("reset_mix_out", 32'(mix_out), 32'h80);
    check("reset_bram_addr", 32'(bram_addr), 32'h0);

    // Directed cases from the ramp / constant BRAM patterns.
    mode = 0;
    run_tick(8'h01, 13'(16'h1234));
    run_tick(8'h0C, 13'(16'h0ABC));
    mode = 1;
    run_tick(8'hFF, 13'h1FFF);
    mode = 2;
    run_tick(8'hFF, 13'h0000);
    mode = 3;
    run_tick(8'h00, 13'(16'h0555));

    // Tick while busy and gate change after capture are both ignored.
    mode = 0;
    a    = 13'(16'h0777);
    exp  = model(8'h0C, a);
    nvalid = 0;
    seen_k = -1;
    got    = 8'h00;
    sample_tick = 1'b1;
    gate_in     = 8'h0C;
    sample_addr = a;
    step();
    for (int k = 1; k <= 24; k++) begin
      if (mix_valid) begin
        nvalid++;
        seen_k = k;
        got    = mix_out;
      end
      if (k == 3) gate_in = 8'hFF;
      sample_tick = (k == 5);
      step();
    end
    sample_tick = 1'b0;
    check("busy_tick_count", 32'(nvalid), 32'd1);
    check("busy_tick_cycle", 32'(seen_k), 32'd11);
    check("busy_tick_mix", 32'(got), 32'(exp));

    // Reset mid-sequence aborts; a later tick is accepted normally.
    mode = 0;
    nvalid = 0;
    seen_k = -1;
    got    = 8'h00;
    sample_tick = 1'b1;
    gate_in     = 8'hFF;
    sample_addr = 13'h0100;
    step();
    sample_tick = 1'b0;
    a   = 13'h0200;
    exp = model(8'h0C, a);
    for (int k = 1; k <= 22; k++) begin
      if (k == 7) begin
        check("abort_mix_out", 32'(mix_out), 32'h80);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bram_addr", 32'(bram_addr), 32'h0);
      end
      if (mix_valid) begin
        nvalid++;
        seen_k = k;
        got    = mix_out;
      end
      rst_in      = (k == 6);
      sample_tick = (k == 8);
      if (k == 8) begin
        gate_in     = 8'h0C;
        sample_addr = a;
      end
      step();
    end
    sample_tick = 1'b0;
    rst_in      = 1'b0;
    check("abort_valid_count", 32'(nvalid), 32'd1);
    check("abort_valid_cycle", 32'(seen_k), 32'd19);
    check("abort_mix", 32'(got), 32'(exp));

    // Randomized mixes over a random BRAM image.
    mode = 3;
    for (int t = 0; t < 40; t++) begin
      run_tick(8'($urandom), 13'($urandom));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
